// File: rtl/sweep_ctrl_if.sv
// Sweep control bundle between the host and sweep_ctrl.
//   master: host side, drives start/stop/config and observes sequencer outputs
//   slave : sweep_ctrl side
// Signals:
//   start, stop               control strobes
//   mode                      sweep mode (00 one-shot up, 01 loop up, 10 up-down, 11 ping-pong)
//   incr_lo, incr_hi          inclusive sweep bounds
//   incr_step                 amount added/subtracted per step
//   dwell                     cycles per incr value (0 behaves as 1)
//   en, incr                  counter enable/increment towards sinegen
//   busy, done, err           status
interface sweep_ctrl_if #(
  parameter int unsigned D_WIDTH     = 8,
  parameter int unsigned DWELL_WIDTH = 16
);
  logic                   start;
  logic                   stop;
  logic [1:0]             mode;
  logic [D_WIDTH-1:0]     incr_lo;
  logic [D_WIDTH-1:0]     incr_hi;
  logic [D_WIDTH-1:0]     incr_step;
  logic [DWELL_WIDTH-1:0] dwell;
  logic                   en;
  logic [D_WIDTH-1:0]     incr;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output start, stop, mode, incr_lo, incr_hi, incr_step, dwell,
    input  en, incr, busy, done, err
  );

  modport slave (
    input  start, stop, mode, incr_lo, incr_hi, incr_step, dwell,
    output en, incr, busy, done, err
  );
endinterface

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer for the sine generator datapath. Steps the address
// counter increment from a low to a high bound, holding each value for a
// programmable dwell; supports one-shot, looping, up-down and ping-pong sweeps.
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   if_sweep  sweep_ctrl_if slave: start/stop/config in, en/incr/busy/done/err out
// All outputs are registered.
module sweep_ctrl #(
  parameter int unsigned D_WIDTH     = 8,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  sweep_ctrl_if.slave   if_sweep
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic DirUp   = 1'b0;
  localparam logic DirDown = 1'b1;

  state_e                 r_state, w_state_nxt;
  logic                   r_en, r_busy, r_done, r_err;
  logic [D_WIDTH-1:0]     r_incr, w_incr_nxt;
  logic                   r_dir, w_dir_nxt;
  logic [DWELL_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                   w_done_nxt, w_err_nxt, w_latch;

  // Configuration captured on an accepted start
  logic [1:0]             r_mode;
  logic [D_WIDTH-1:0]     r_lo, r_hi, r_step;
  logic [DWELL_WIDTH-1:0] r_dwell;

  logic [D_WIDTH:0]       w_up_sum, w_dn_diff;
  logic                   w_up_ok, w_dn_ok;
  logic [DWELL_WIDTH-1:0] w_dwell_last;
  logic                   w_step_evt;

  // One extra bit so an upward step past the top of the range never wraps and
  // a downward step below zero shows up as a borrow.
  assign w_up_sum  = {1'b0, r_incr} + {1'b0, r_step};
  assign w_dn_diff = {1'b0, r_incr} - {1'b0, r_step};
  assign w_up_ok   = (r_step != '0) && (w_up_sum <= {1'b0, r_hi});
  assign w_dn_ok   = (r_step != '0) && !w_dn_diff[D_WIDTH] &&
                     (w_dn_diff[D_WIDTH-1:0] >= r_lo);

  // dwell of 0 behaves as 1: step every cycle
  assign w_dwell_last = (r_dwell == '0) ? '0 : r_dwell - DWELL_WIDTH'(1);
  assign w_step_evt   = (r_cnt == w_dwell_last);

  always_comb begin
    w_state_nxt = r_state;
    w_incr_nxt  = r_incr;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_latch     = 1'b0;

    case (r_state)
      StIdle: begin
        if (if_sweep.start) begin
          if (if_sweep.incr_lo <= if_sweep.incr_hi) begin
            w_state_nxt = StRun;
            w_incr_nxt  = if_sweep.incr_lo;
            w_dir_nxt   = DirUp;
            w_cnt_nxt   = '0;
            w_latch     = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      StRun: begin
        if (if_sweep.stop) begin
          // stop overrides any step or finish due this cycle
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end else if (w_step_evt) begin
          w_cnt_nxt = '0;
          if (r_dir == DirUp) begin
            if (w_up_ok) begin
              w_incr_nxt = w_up_sum[D_WIDTH-1:0];
            end else begin
              case (r_mode)
                2'b00: begin
                  w_state_nxt = StIdle;
                  w_done_nxt  = 1'b1;
                end
                2'b01: w_incr_nxt = r_lo;
                default: begin
                  // Turn around at the top within the same step
                  w_dir_nxt = DirDown;
                  if (w_dn_ok) begin
                    w_incr_nxt = w_dn_diff[D_WIDTH-1:0];
                  end else if (r_mode == 2'b10) begin
                    w_state_nxt = StIdle;
                    w_done_nxt  = 1'b1;
                  end
                end
              endcase
            end
          end else begin
            if (w_dn_ok) begin
              w_incr_nxt = w_dn_diff[D_WIDTH-1:0];
            end else if (r_mode == 2'b11) begin
              w_dir_nxt = DirUp;
              if (w_up_ok) begin
                w_incr_nxt = w_up_sum[D_WIDTH-1:0];
              end
            end else begin
              w_state_nxt = StIdle;
              w_done_nxt  = 1'b1;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + DWELL_WIDTH'(1);
        end
      end

      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_incr  <= '0;
      r_dir   <= DirUp;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
      r_lo    <= '0;
      r_hi    <= '0;
      r_step  <= '0;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= (w_state_nxt == StRun);
      r_busy  <= (w_state_nxt == StRun);
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_incr  <= w_incr_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_mode  <= if_sweep.mode;
        r_lo    <= if_sweep.incr_lo;
        r_hi    <= if_sweep.incr_hi;
        r_step  <= if_sweep.incr_step;
        r_dwell <= if_sweep.dwell;
      end
    end
  end

  assign if_sweep.en   = r_en;
  assign if_sweep.incr = r_incr;
  assign if_sweep.busy = r_busy;
  assign if_sweep.done = r_done;
  assign if_sweep.err  = r_err;

endmodule
